dmem_arbiter: RTL and testbench

Shares the single data memory port between the processor load/store path (CPU) and a memory loader/debug port (LDR). It arbitrates round-robin under contention, supports a loader lock for exclusive bursts, returns read data with a one-cycle latency tag, and drives a stall to the processor when its access is deferred. It sits between the processor's data-memory connections and the data memory array.

---
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU load/store path and the
// loader/debug port: round-robin under contention, loader lock, 1-cycle read tag.
module dmem_arbiter #(
   parameter int AW = 5,
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          ldr_req,
   input  logic          ldr_we,
   input  logic [AW-1:0] ldr_addr,
   input  logic [DW-1:0] ldr_wdata,
   input  logic          ldr_lock,
   output logic          ldr_gnt,
   output logic          ldr_rvalid,
   output logic [DW-1:0] ldr_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [CW-1:0] conflict_cnt
);

   localparam logic ST_ARB    = 1'b0;
   localparam logic ST_LOCKED = 1'b1;
   localparam logic PORT_CPU  = 1'b0;
   localparam logic PORT_LDR  = 1'b1;

   logic          state_q, state_d;
   logic          last_q, last_d;
   logic          tag_vld_q, tag_vld_d;
   logic          tag_port_q, tag_port_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          cpu_sel, ldr_sel;
   logic          conflict;

   // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      cpu_sel = 1'b0;
      ldr_sel = 1'b0;
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         ST_ARB: begin
            if (ldr_req && ldr_lock) begin
               ldr_sel = 1'b1;
               state_d = ST_LOCKED;
            end else if (cpu_req && ldr_req) begin
               cpu_sel = (last_q == PORT_LDR);
               ldr_sel = (last_q == PORT_CPU);
            end else begin
               cpu_sel = cpu_req;
               ldr_sel = ldr_req;
            end
         end
         ST_LOCKED: begin
            ldr_sel = ldr_req;
            if (!ldr_lock) begin
               state_d = ST_ARB;
            end
         end
         default: state_d = ST_ARB;
      endcase
      if (cpu_sel) last_d = PORT_CPU;
      if (ldr_sel) last_d = PORT_LDR;
      // Leaving a lock always hands the next conflict to the CPU.
      if (state_q == ST_LOCKED && !ldr_lock) last_d = PORT_LDR;
   end

   assign cpu_gnt   = cpu_sel & rst_n;
   assign ldr_gnt   = ldr_sel & rst_n;
   assign mem_en    = cpu_gnt | ldr_gnt;
   assign cpu_stall = cpu_req & ~cpu_gnt & rst_n;

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (ldr_gnt) begin
         mem_we    = ldr_we;
         mem_addr  = ldr_addr;
         mem_wdata = ldr_wdata;
      end else if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end
   end

   assign tag_vld_d  = mem_en & ~mem_we;
   assign tag_port_d = ldr_gnt ? PORT_LDR : PORT_CPU;

   assign conflict = (cpu_req & ~cpu_gnt & ldr_gnt) | (ldr_req & ~ldr_gnt & cpu_gnt);
   assign cnt_d    = (conflict && (cnt_q != {CW{1'b1}})) ? cnt_q + CW'(1) : cnt_q;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_ARB;
         last_q     <= PORT_LDR;
         tag_vld_q  <= 1'b0;
         tag_port_q <= PORT_CPU;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         tag_vld_q  <= tag_vld_d;
         tag_port_q <= tag_port_d;
         cnt_q      <= cnt_d;
      end
   end

   // Qualifiers are masked during reset so a read in flight is dropped immediately.
   assign cpu_rvalid   = rst_n & tag_vld_q & (tag_port_q == PORT_CPU);
   assign ldr_rvalid   = rst_n & tag_vld_q & (tag_port_q == PORT_LDR);
   assign cpu_rdata    = mem_rdata;
   assign ldr_rdata    = mem_rdata;
   assign conflict_cnt = rst_n ? cnt_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level
// reference model; a second instance with a 4-bit counter exercises saturation.
module tb_dmem_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
   logic [AW-1:0] ldr_addr = '0;
   logic [DW-1:0] ldr_wdata = '0;
   logic [DW-1:0] mem_rdata = '0;

   logic          cpu_gnt, cpu_rvalid, cpu_stall, ldr_gnt, ldr_rvalid, mem_en, mem_we;
   logic [DW-1:0] cpu_rdata, ldr_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic [15:0]   conflict_cnt;

   logic          s_cpu_gnt, s_cpu_rvalid, s_cpu_stall, s_ldr_gnt, s_ldr_rvalid, s_mem_en, s_mem_we;
   logic [DW-1:0] s_cpu_rdata, s_ldr_rdata, s_mem_wdata;
   logic [AW-1:0] s_mem_addr;
   logic [3:0]    s_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(AW), .DW(DW), .CW(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
   );

   dmem_arbiter #(.AW(AW), .DW(DW), .CW(4)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(s_cpu_gnt), .cpu_rvalid(s_cpu_rvalid), .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_lock(ldr_lock), .ldr_gnt(s_ldr_gnt), .ldr_rvalid(s_ldr_rvalid), .ldr_rdata(s_ldr_rdata),
      .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_rdata(mem_rdata), .conflict_cnt(s_cnt)
   );

   // Physical memory behind the port: big-endian words, 1-cycle read.
   logic [7:0] mem_arr [32];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            mem_arr[mem_addr]        <= mem_wdata[31:24];
            mem_arr[mem_addr + 5'd1] <= mem_wdata[23:16];
            mem_arr[mem_addr + 5'd2] <= mem_wdata[15:8];
            mem_arr[mem_addr + 5'd3] <= mem_wdata[7:0];
         end else begin
            mem_rdata <= {mem_arr[mem_addr], mem_arr[mem_addr + 5'd1],
                          mem_arr[mem_addr + 5'd2], mem_arr[mem_addr + 5'd3]};
         end
      end
   end

   // Reference model state
   logic [7:0]  ref_mem [32];
   bit          m_locked, m_last_ldr, m_pv, m_pport;
   logic [31:0] m_pdata;
   int          m_cnt, m_cnt4;
   bit          e_cg, e_lg;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [4:0] a);
      return {ref_mem[a], ref_mem[a + 5'd1], ref_mem[a + 5'd2], ref_mem[a + 5'd3]};
   endfunction

   // One clock cycle: called at a negedge with inputs already applied.
   task automatic step();
      bit          e_en, e_we, e_crv, e_lrv, e_stall;
      logic [4:0]  e_addr;
      logic [31:0] e_wd;
      #1;
      e_cg = 0; e_lg = 0; e_we = 0; e_addr = '0; e_wd = '0;
      e_crv = 0; e_lrv = 0;
      if (rst_n) begin
         if (m_locked) e_lg = ldr_req;
         else if (ldr_req && ldr_lock) e_lg = 1;
         else if (cpu_req && ldr_req) begin e_cg = m_last_ldr; e_lg = !m_last_ldr; end
         else begin e_cg = cpu_req; e_lg = ldr_req; end
         if (e_lg) begin e_we = ldr_we; e_addr = ldr_addr; e_wd = ldr_wdata; end
         else if (e_cg) begin e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; end
         e_crv = m_pv && !m_pport;
         e_lrv = m_pv && m_pport;
      end
      e_en    = e_cg || e_lg;
      e_stall = rst_n && cpu_req && !e_cg;

      check("cpu_gnt", cpu_gnt, e_cg);
      check("ldr_gnt", ldr_gnt, e_lg);
      check("cpu_stall", cpu_stall, e_stall);
      check("mem_en", mem_en, e_en);
      check("mem_we", mem_we, e_we);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wd);
      check("cpu_rvalid", cpu_rvalid, e_crv);
      check("ldr_rvalid", ldr_rvalid, e_lrv);
      if (e_crv) check("cpu_rdata", cpu_rdata, m_pdata);
      if (e_lrv) check("ldr_rdata", ldr_rdata, m_pdata);
      check("conflict_cnt", conflict_cnt, rst_n ? m_cnt : 0);
      check("conflict_cnt4", s_cnt, rst_n ? m_cnt4 : 0);

      if (!rst_n) begin
         m_locked = 0; m_last_ldr = 1; m_pv = 0; m_pport = 0; m_cnt = 0; m_cnt4 = 0;
      end else begin
         if ((cpu_req && !e_cg && e_lg) || (ldr_req && !e_lg && e_cg)) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
         end
         m_pv = e_en && !e_we;
         m_pport = e_lg;
         if (m_pv) m_pdata = ref_word(e_addr);
         if (e_en && e_we) begin
            ref_mem[e_addr]        = e_wd[31:24];
            ref_mem[e_addr + 5'd1] = e_wd[23:16];
            ref_mem[e_addr + 5'd2] = e_wd[15:8];
            ref_mem[e_addr + 5'd3] = e_wd[7:0];
         end
         if (e_cg) m_last_ldr = 0;
         if (e_lg) m_last_ldr = 1;
         if (m_locked) begin
            if (!ldr_lock) begin m_locked = 0; m_last_ldr = 1; end
         end else if (ldr_req && ldr_lock) begin
            m_locked = 1;
         end
      end
      @(negedge clk);
   endtask

   function automatic logic [4:0] rand_addr();
      return 5'($urandom_range(7) * 4);
   endfunction

   task automatic rand_cpu(input int pct);
      if (!cpu_req || e_cg) begin
         cpu_req   = ($urandom_range(99) < pct);
         cpu_we    = 1'($urandom_range(1));
         cpu_addr  = rand_addr();
         cpu_wdata = $urandom;
      end
   endtask

   task automatic rand_ldr(input int pct);
      if (!ldr_req || e_lg) begin
         ldr_req   = ($urandom_range(99) < pct);
         ldr_we    = 1'($urandom_range(1));
         ldr_addr  = rand_addr();
         ldr_wdata = $urandom;
      end
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) step();
      rst_n = 1'b1;
   endtask

   initial begin
      int lock_pct;
      for (int i = 0; i < 32; i++) begin
         mem_arr[i] = 8'(i * 7 + 3);
         ref_mem[i] = 8'(i * 7 + 3);
      end
      mem_arr[4] = 8'h11; mem_arr[5] = 8'h22; mem_arr[6] = 8'h33; mem_arr[7] = 8'h44;
      ref_mem[4] = 8'h11; ref_mem[5] = 8'h22; ref_mem[6] = 8'h33; ref_mem[7] = 8'h44;
      m_locked = 0; m_last_ldr = 1; m_pv = 0; m_pport = 0; m_pdata = '0; m_cnt = 0; m_cnt4 = 0;

      @(negedge clk);
      do_reset(2);

      // CPU-only read of the preloaded word
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'd4;
      step();
      cpu_req = 0;
      check("cpu_rd_rvalid", cpu_rvalid, 1'b1);
      check("cpu_rd_data", cpu_rdata, 32'h11223344);
      check("cpu_rd_ldr_rvalid", ldr_rvalid, 1'b0);
      check("cpu_rd_cnt", conflict_cnt, 16'd0);
      step();

      // Dual continuous reads right after reset
      do_reset(1);
      for (int i = 0; i < 6; i++) begin
         cpu_req = 1; ldr_req = 1; ldr_lock = 0;
         if (i == 0 || e_cg) begin cpu_we = 0; cpu_addr = rand_addr(); end
         if (i == 0 || e_lg) begin ldr_we = 0; ldr_addr = rand_addr(); end
         step();
      end
      check("dual_cnt6", conflict_cnt, 16'd6);
      cpu_req = 0; ldr_req = 0;
      step();

      // Locked burst of four loader writes with the CPU waiting
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'd16;
      for (int i = 0; i < 4; i++) begin
         ldr_req = 1; ldr_we = 1; ldr_addr = 5'(i * 4); ldr_wdata = $urandom;
         ldr_lock = (i < 3);
         step();
      end
      ldr_req = 0; ldr_lock = 0;
      #1 check("lock_exit_cpu_gnt", cpu_gnt, 1'b1);
      step();
      cpu_req = 0;
      step();

      // Lock without a loader request has no effect
      ldr_lock = 1; ldr_req = 0;
      for (int i = 0; i < 4; i++) begin
         cpu_req = 1; cpu_we = 1'($urandom_range(1)); cpu_addr = rand_addr(); cpu_wdata = $urandom;
         step();
      end
      ldr_lock = 0; cpu_req = 0;
      step();

      // Reset lands on the cycle after a CPU read grant
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'd8;
      step();
      cpu_req = 0;
      rst_n = 0;
      step();
      rst_n = 1;
      step();

      // Sustained contention saturates the 4-bit counter
      do_reset(1);
      for (int i = 0; i < 20; i++) begin
         cpu_req = 1; ldr_req = 1;
         if (i == 0 || e_cg) begin cpu_we = 1'($urandom_range(1)); cpu_addr = rand_addr(); cpu_wdata = $urandom; end
         if (i == 0 || e_lg) begin ldr_we = 1'($urandom_range(1)); ldr_addr = rand_addr(); ldr_wdata = $urandom; end
         step();
      end
      check("sat_cnt4", s_cnt, 4'd15);
      check("cnt16_after20", conflict_cnt, 16'd20);

      // Random traffic with varying lock pressure and occasional reset
      lock_pct = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) lock_pct = ($urandom_range(2) == 0) ? 0 : (($urandom_range(1) == 0) ? 10 : 60);
         rand_cpu(70);
         rand_ldr(50);
         ldr_lock = ($urandom_range(99) < lock_pct);
         rst_n = ($urandom_range(299) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
